processor_exec_stage: RTL
=========================

Name: processor_exec_stage

Overview:
- Parametrised final pipeline stage: execute, writeback, branch resolution and WAIT handling.
- Receives decoded operands from stage 2 and drives the register-file write port, the IP redirect and the stall back-pressure.
- Unlike the single-cycle stage, it has:
  - a registered writeback;
  - a multi-cycle multiply;
  - a WAIT/continue handshake;
  - IF/CALL/RETURN redirects with a post-redirect squash window.

Parameters:
- ADDR_SIZE, 18, instruction-pointer and address width.
- WORD_SIZE, 18, data word width; code_word is also WORD_SIZE wide.
- REG_ADDR_BITS, 3, register index width (code_word[13:11] at default).
- MUL_LATENCY, 3, cycles from OP_MUL_SHIFT accept to writeback. Range 1..8.
- SQUASH_SLOTS, 2, number of accepted-cycle slots ignored after a redirect. Range 0..3.
- LINK_REG, 7, register that receives the return address on OP_CALL_IMM14.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- no_operation  in  1  1 = no instruction presented this cycle.
- alu_data0  in  WORD_SIZE  rx value.
- alu_data1  in  WORD_SIZE  ry value.
- data1_plus_imm8  in  ADDR_SIZE  ry + imm8 (memory address or add result).
- code_word  in  WORD_SIZE  instruction; opcode is [17:14].
- ip  in  ADDR_SIZE  address of this instruction.
- memory_out  in  WORD_SIZE  data read at data1_plus_imm8; valid in the accept cycle.
- continue_in  in  1  releases WAIT.
- stall_out  out  1  1 = upstream must hold its current inputs.
- reg_write_enable  out  1  registered write strobe.
- reg_write_addr  out  REG_ADDR_BITS  registered write index.
- reg_write_data  out  WORD_SIZE  registered write data.
- wait_for_continue_out  out  1  high while in WAIT.
- ip_to_call  out  ADDR_SIZE  redirect target.
- call_performed  out  1  one-cycle redirect pulse.

Behaviour:
- Reset (async): all outputs 0, state RUN, squash counter 0, multiply counter 0.
- Accept: the stage accepts an instruction when all hold: state RUN, no_operation=0, squash counter 0.
- Squash: when state is RUN, no_operation=0 and the squash counter is nonzero, the instruction is discarded and the counter decrements.
- Writeback: registered; data appears on the edge after accept.
  - reg_write_enable is high exactly one cycle per writing instruction.
  - reg_write_addr = code_word[13:11].
- Writeback data by opcode:
  - OP_REG_ADD_IMM8: data1_plus_imm8.
  - OP_REG_MOV_IMM11: sign-extended code_word[10:0].
  - OP_REG_MOV_IMM11_TOP: code_word[10:0]<<7.
  - OP_LOAD_FROM_MEMORY: memory_out.
  - OP_ALU: alu result, op from code_word.
  - OP_WRITE_TO_MEMORY: no write.
- OP_MUL_SHIFT:
  - Result is the low WORD_SIZE bits of (unsigned rx × unsigned ry), full 2·WORD_SIZE product, shifted right by code_word[4:0].
  - State goes RUN→MUL. stall_out is high for MUL_LATENCY-1 cycles, then the result is written.
  - With MUL_LATENCY=1 there is no stall.
  - Operands are captured at accept.
- OP_IF: if if_ok then ip_to_call = ip + sign-extended code_word[7:0] (mod 2^ADDR_SIZE) and call_performed pulses on the next edge.
- OP_CALL_IMM14: ip_to_call = zero-extended code_word[13:0]; LINK_REG is written with ip+1; call_performed pulses.
- OP_RETURN: ip_to_call = memory_out; call_performed pulses.
- Redirect squash: a redirect loads the squash counter with SQUASH_SLOTS.
- OP_WAIT:
  - State goes RUN→WAIT. wait_for_continue_out and stall_out go high from the next edge.
  - Exit: continue_in=1 sampled in WAIT returns state to RUN on that edge. Both outputs drop after that edge.
  - continue_in is ignored outside WAIT.
- Simultaneous events:
  - continue_in during the WAIT accept cycle is ignored; WAIT is still entered.
  - Inputs while stall_out=1 are not accepted and not squashed.
- Unknown opcodes: no write, no redirect.
- reset mid-MUL or mid-WAIT: pending result or wait is discarded and no write occurs.

Test Plan:
- MOV_IMM11 code rx=3, imm=0x7FF → one cycle later we=1, addr=3, data=0x3FFFF.
- MUL_SHIFT rx=1000, ry=300, shift=4, MUL_LATENCY=3 → stall 2 cycles, then data=18750, one write pulse.
- IF taken at ip=0x100, imm8=0xFE → call_performed=1, ip_to_call=0x0FE; next 2 valid instructions produce no write or redirect.
- CALL imm14=0x1234 at ip=0x20 → ip_to_call=0x1234, r7 written with 0x21.
- WAIT, continue_in held low 5 cycles then pulsed → wait_for_continue_out high 5+1 cycles, then a following ADD is accepted.
- Assert reset during MUL stall → all outputs 0 immediately, no write after release.

Source files
------------

// File: rtl/processor_exec_stage.sv
// Final pipeline stage: execute, registered writeback, branch resolution and WAIT handling.
// Multiply runs over several cycles; redirects squash a fixed number of following instructions.
module processor_exec_stage #(
  parameter int ADDR_SIZE     = 18,
  parameter int WORD_SIZE     = 18,
  parameter int REG_ADDR_BITS = 3,
  parameter int MUL_LATENCY   = 3,
  parameter int SQUASH_SLOTS  = 2,
  parameter int LINK_REG      = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     no_operation,
  input  logic [WORD_SIZE-1:0]     alu_data0,
  input  logic [WORD_SIZE-1:0]     alu_data1,
  input  logic [ADDR_SIZE-1:0]     data1_plus_imm8,
  input  logic [WORD_SIZE-1:0]     code_word,
  input  logic [ADDR_SIZE-1:0]     ip,
  input  logic [WORD_SIZE-1:0]     memory_out,
  input  logic                     continue_in,
  output logic                     stall_out,
  output logic                     reg_write_enable,
  output logic [REG_ADDR_BITS-1:0] reg_write_addr,
  output logic [WORD_SIZE-1:0]     reg_write_data,
  output logic                     wait_for_continue_out,
  output logic [ADDR_SIZE-1:0]     ip_to_call,
  output logic                     call_performed
);

  localparam logic [3:0] OP_REG_ADD_IMM8      = 4'h0;
  localparam logic [3:0] OP_REG_MOV_IMM11     = 4'h1;
  localparam logic [3:0] OP_REG_MOV_IMM11_TOP = 4'h2;
  localparam logic [3:0] OP_LOAD_FROM_MEMORY  = 4'h3;
  localparam logic [3:0] OP_WRITE_TO_MEMORY   = 4'h4;
  localparam logic [3:0] OP_ALU               = 4'h5;
  localparam logic [3:0] OP_MUL_SHIFT         = 4'h6;
  localparam logic [3:0] OP_IF                = 4'h7;
  localparam logic [3:0] OP_CALL_IMM14        = 4'h8;
  localparam logic [3:0] OP_RETURN            = 4'h9;
  localparam logic [3:0] OP_WAIT              = 4'hA;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MUL,
    ST_WAIT
  } state_t;

  state_t                     state;
  logic [1:0]                 squash_count;
  logic [3:0]                 mul_count;
  logic [WORD_SIZE-1:0]       mul_a;
  logic [WORD_SIZE-1:0]       mul_b;
  logic [4:0]                 mul_shift;
  logic [REG_ADDR_BITS-1:0]   mul_dest;

  logic [3:0]                 opcode;
  logic [REG_ADDR_BITS-1:0]   dest;
  logic                       accept;
  logic                       squash;

  assign opcode = code_word[WORD_SIZE-1 -: 4];
  assign dest   = code_word[WORD_SIZE-5 -: REG_ADDR_BITS];
  assign accept = (state == ST_RUN) && !no_operation && (squash_count == 2'd0);
  assign squash = (state == ST_RUN) && !no_operation && (squash_count != 2'd0);

  // Branch condition in code_word[10:8], evaluated on rx/ry.
  logic if_ok;
  always_comb begin
    if_ok = 1'b0;
    case (code_word[10:8])
      3'd0: if_ok = 1'b1;
      3'd1: if_ok = (alu_data0 == '0);
      3'd2: if_ok = (alu_data0 != '0);
      3'd3: if_ok = alu_data0[WORD_SIZE-1];
      3'd4: if_ok = !alu_data0[WORD_SIZE-1];
      3'd5: if_ok = (alu_data0 == alu_data1);
      3'd6: if_ok = (alu_data0 != alu_data1);
      3'd7: if_ok = (alu_data0 < alu_data1);
      default: if_ok = 1'b0;
    endcase
  end

  logic [WORD_SIZE-1:0] alu_result;
  always_comb begin
    alu_result = '0;
    case (code_word[2:0])
      3'd0: alu_result = alu_data0 + alu_data1;
      3'd1: alu_result = alu_data0 - alu_data1;
      3'd2: alu_result = alu_data0 & alu_data1;
      3'd3: alu_result = alu_data0 | alu_data1;
      3'd4: alu_result = alu_data0 ^ alu_data1;
      3'd5: alu_result = alu_data0 << alu_data1[4:0];
      3'd6: alu_result = alu_data0 >> alu_data1[4:0];
      3'd7: alu_result = ~alu_data0;
      default: alu_result = '0;
    endcase
  end

  // One multiplier shared between the single-cycle and the held-operand paths.
  logic [WORD_SIZE-1:0]   op_a;
  logic [WORD_SIZE-1:0]   op_b;
  logic [4:0]             shift_sel;
  logic [2*WORD_SIZE-1:0] product;
  logic [WORD_SIZE-1:0]   mul_result;
  always_comb begin
    op_a       = (state == ST_MUL) ? mul_a : alu_data0;
    op_b       = (state == ST_MUL) ? mul_b : alu_data1;
    shift_sel  = (state == ST_MUL) ? mul_shift : code_word[4:0];
    product    = (2*WORD_SIZE)'(op_a) * (2*WORD_SIZE)'(op_b);
    mul_result = WORD_SIZE'(product >> shift_sel);
  end

  logic                     wb_en;
  logic [REG_ADDR_BITS-1:0] wb_addr;
  logic [WORD_SIZE-1:0]     wb_data;
  logic                     redirect;
  logic [ADDR_SIZE-1:0]     redirect_target;
  logic                     start_mul;
  logic                     start_wait;
  always_comb begin
    wb_en           = 1'b0;
    wb_addr         = dest;
    wb_data         = '0;
    redirect        = 1'b0;
    redirect_target = '0;
    start_mul       = 1'b0;
    start_wait      = 1'b0;
    case (opcode)
      OP_REG_ADD_IMM8: begin
        wb_en   = 1'b1;
        wb_data = WORD_SIZE'(data1_plus_imm8);
      end
      OP_REG_MOV_IMM11: begin
        wb_en   = 1'b1;
        wb_data = {{(WORD_SIZE-11){code_word[10]}}, code_word[10:0]};
      end
      OP_REG_MOV_IMM11_TOP: begin
        wb_en   = 1'b1;
        wb_data = WORD_SIZE'({code_word[10:0], 7'b0});
      end
      OP_LOAD_FROM_MEMORY: begin
        wb_en   = 1'b1;
        wb_data = memory_out;
      end
      OP_WRITE_TO_MEMORY: begin
      end
      OP_ALU: begin
        wb_en   = 1'b1;
        wb_data = alu_result;
      end
      OP_MUL_SHIFT: begin
        if (MUL_LATENCY == 1) begin
          wb_en   = 1'b1;
          wb_data = mul_result;
        end else begin
          start_mul = 1'b1;
        end
      end
      OP_IF: begin
        if (if_ok) begin
          redirect        = 1'b1;
          redirect_target = ip + {{(ADDR_SIZE-8){code_word[7]}}, code_word[7:0]};
        end
      end
      OP_CALL_IMM14: begin
        redirect        = 1'b1;
        redirect_target = ADDR_SIZE'(code_word[13:0]);
        wb_en           = 1'b1;
        wb_addr         = REG_ADDR_BITS'(LINK_REG);
        wb_data         = WORD_SIZE'(ip + 1'b1);
      end
      OP_RETURN: begin
        redirect        = 1'b1;
        redirect_target = ADDR_SIZE'(memory_out);
      end
      OP_WAIT: start_wait = 1'b1;
      default: begin
      end
    endcase
  end

  // Stall and wait outputs are registered copies of the state, so upstream
  // holds exactly while the stage is in MUL or WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= ST_RUN;
      squash_count          <= 2'd0;
      mul_count             <= 4'd0;
      mul_a                 <= '0;
      mul_b                 <= '0;
      mul_shift             <= 5'd0;
      mul_dest              <= '0;
      stall_out             <= 1'b0;
      reg_write_enable      <= 1'b0;
      reg_write_addr        <= '0;
      reg_write_data        <= '0;
      wait_for_continue_out <= 1'b0;
      ip_to_call            <= '0;
      call_performed        <= 1'b0;
    end else begin
      reg_write_enable <= 1'b0;
      call_performed   <= 1'b0;
      case (state)
        ST_RUN: begin
          if (squash) begin
            squash_count <= squash_count - 2'd1;
          end else if (accept) begin
            if (wb_en) begin
              reg_write_enable <= 1'b1;
              reg_write_addr   <= wb_addr;
              reg_write_data   <= wb_data;
            end
            if (redirect) begin
              call_performed <= 1'b1;
              ip_to_call     <= redirect_target;
              squash_count   <= 2'(SQUASH_SLOTS);
            end
            if (start_mul) begin
              state     <= ST_MUL;
              stall_out <= 1'b1;
              mul_count <= 4'(MUL_LATENCY - 1);
              mul_a     <= alu_data0;
              mul_b     <= alu_data1;
              mul_shift <= code_word[4:0];
              mul_dest  <= dest;
            end
            if (start_wait) begin
              state                 <= ST_WAIT;
              stall_out             <= 1'b1;
              wait_for_continue_out <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_count <= 4'd1) begin
            reg_write_enable <= 1'b1;
            reg_write_addr   <= mul_dest;
            reg_write_data   <= mul_result;
            state            <= ST_RUN;
            stall_out        <= 1'b0;
            mul_count        <= 4'd0;
          end else begin
            mul_count <= mul_count - 4'd1;
          end
        end
        ST_WAIT: begin
          if (continue_in) begin
            state                 <= ST_RUN;
            stall_out             <= 1'b0;
            wait_for_continue_out <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
